reg_write_demux: RTL

//  Write-side counterpart of the register-file read mux tree. Decodes a write

---
 rtl/reg_write_demux.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_write_demux.sv
// reg_write_demux
// Write side of the register file. A write address is decoded to a one-hot
// select and the write data lands in one of NUM_REGS holding registers, which
// are all exported flat for the read mux tree. A bulk-clear engine zeroes one
// register per cycle while it holds off new writes.
//
// Handshake: a write commits on a rising CLK edge where WR_VALID and WR_READY
// are both 1. WR_READY is high exactly while the engine is IDLE and depends
// only on registered state, never on WR_VALID. A requester may keep WR_VALID
// asserted with stable WR_ADDR/WR_DATA for as long as WR_READY is low.
module reg_write_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   WR_VALID,
  output logic                                   WR_READY,
  input  logic [ADDR_WIDTH-1:0]                  WR_ADDR,
  input  logic [DATA_WIDTH-1:0]                  WR_DATA,
  input  logic                                   CLR_REQ,
  output logic                                   CLR_BUSY,
  output logic [(2**ADDR_WIDTH)-1:0]             WR_SEL,
  output logic                                   WR_DONE,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  REG_FLAT,
  output logic                                   DBG_STATE,
  output logic [ADDR_WIDTH-1:0]                  DBG_CLR_CNT
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0]     wr_sel;
  logic                    wr_done;
  logic                    wr_to_zero_reg;

  // A write to index 0 is discarded when register 0 is hardwired to zero.
  assign wr_to_zero_reg = (ZERO_REG != 0) && (WR_ADDR == '0);

  // Control FSM, clear sweep, register writes and the registered write strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      wr_sel  <= '0;
      wr_done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          wr_done <= 1'b0;
          wr_sel  <= '0;
          // A write offered on the same edge as a clear request commits
          // first; the sweep that follows zeroes it in its turn.
          if (WR_VALID) begin
            wr_done <= 1'b1;
            if (!wr_to_zero_reg) begin
              regs[WR_ADDR] <= WR_DATA;
              wr_sel        <= NUM_REGS'(1) << WR_ADDR;
            end
          end
          if (CLR_REQ) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          wr_done        <= 1'b0;
          wr_sel         <= '0;
          regs[clr_cnt]  <= '0;
          // Terminal count is compared explicitly rather than relying on the
          // counter wrapping back to zero.
          if (clr_cnt == LAST_IDX) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          clr_cnt <= '0;
          wr_done <= 1'b0;
          wr_sel  <= '0;
        end
      endcase
    end
  end

  // Handshake and status flags come straight from the state register.
  always_comb begin
    WR_READY    = (state == ST_IDLE);
    CLR_BUSY    = (state == ST_CLEAR);
    WR_SEL      = wr_sel;
    WR_DONE     = wr_done;
    DBG_STATE   = (state == ST_CLEAR);
    DBG_CLR_CNT = clr_cnt;
  end

  // Flatten the register array for the read mux tree.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign REG_FLAT[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
